uart_alu_engine: RTL
====================

Name: uart_alu_engine

Overview:
Packet-level command engine between the UART receiver's AXI-stream output and the UART transmitter's AXI-stream input. It parses framed commands from the received byte stream and executes echo, 32-bit add or 32-bit multiply on the payload. Responses go out as a byte stream for the transmitter. Replaces the direct rx-to-tx loopback in the top level.

Parameters:
OP_ECHO, 8'hEC, opcode for echo (payload returned verbatim)
OP_ADD, 8'hAD, opcode for 32-bit wrap-around sum of all operands
OP_MUL, 8'h88, opcode for 32-bit product of all operands (low 32 bits)
ERR_BYTE, 8'hEE, single byte emitted for a malformed or unsupported packet

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
s_axis_tdata  input  8  received byte from the UART receiver
s_axis_tvalid  input  1  received byte valid
s_axis_tready  output  1  engine accepts the byte
m_axis_tdata  output  8  response byte to the UART transmitter
m_axis_tvalid  output  1  response byte valid
m_axis_tready  input  1  transmitter accepts the byte
busy  output  1  high in any state other than HDR with byte count 0
err  output  1  one-cycle pulse when a packet is classified as an error

Behaviour:
- Reset is asynchronous and active-high, with a single clock `clk`. On reset: state HDR, header count 0, acc 0, m_axis_tvalid 0, m_axis_tdata 8'h00, s_axis_tready 0, busy 0, err 0. One cycle after rst deasserts, s_axis_tready goes to 1.
- A byte transfers on either stream when valid && ready at the rising edge of `clk`.
- Packet format: opcode, reserved, len_lo, len_hi. LEN is 16-bit and counts the whole packet including the 4-byte header. Payload length is LEN-4 bytes.
- HDR: s_axis_tready=1. Capture 4 bytes, then classify in the cycle after the 4th byte:
  - LEN<4: go to ERR with no drain.
  - OP_ECHO with LEN=4: return to HDR with no output.
  - OP_ECHO with LEN>4: go to ECHO.
  - OP_ADD or OP_MUL with (LEN-4) nonzero and a multiple of 4: go to ACC.
  - Any other case: go to DRAIN. Unknown opcode, or ADD/MUL with bad length.
- ECHO: single output holding register. s_axis_tready = !m_axis_tvalid || m_axis_tready. An accepted byte loads m_axis_tdata and sets m_axis_tvalid on the next edge. Full throughput at one byte per cycle is required. After the last payload byte is accepted and then sent, return to HDR.
- ACC: s_axis_tready=1. Operands are 32-bit little-endian.
  - On the 4th byte of operand 0, load acc.
  - On the 4th byte of each later operand: acc <= acc+op (ADD) or acc*op (MUL), truncated to 32 bits.
  - After the last payload byte, go to RESP.
- RESP: s_axis_tready=0. Emit acc as 4 bytes, LSB first. m_axis_tvalid is high the cycle after the last payload byte. Each byte advances on a handshake. After the 4th handshake, go to HDR.
- DRAIN: s_axis_tready=1. Discard exactly LEN-4 bytes, then go to ERR.
- ERR: s_axis_tready=0.
  - err pulses 1 cycle on entry.
  - Emit ERR_BYTE once, then go to HDR.
- m_axis_tdata and m_axis_tvalid must stay stable while m_axis_tvalid && !m_axis_tready.
- The payload byte counter is 16-bit and counts down from LEN-4. No wrap is possible.
- rst asserted mid-packet aborts immediately to the reset state. Partial output is dropped.

Optional Feature:
ALU_MUL_EN: when defined, OP_MUL is decoded as above. When undefined, the multiplier is not synthesized (saves ice40 LUTs) and OP_MUL is treated as an unknown opcode: DRAIN, then ERR_BYTE, then an err pulse.

Test Plan:
- Echo: EC 00 07 00 68 69 21 -> m stream 68 69 21; then idle with busy=0.
- Add with overflow: AD 00 0C 00 FF FF FF FF 02 00 00 00 -> 01 00 00 00; err stays 0.
- Mul (ALU_MUL_EN defined): 88 00 10 00 03 00 00 00 05 00 00 00 02 00 00 00 -> 1E 00 00 00. With the macro undefined -> EE and one err pulse.
- Malformed: AD 00 06 00 AA BB -> exactly 2 bytes drained, then EE, then err pulse. Next packet EC 00 05 00 41 -> 41.
- Backpressure: echo 8 bytes with m_axis_tready toggling 1/0 every cycle -> all bytes in order, none lost or duplicated, m_axis_tdata stable while stalled.
- Reset mid-RESP: rst after the 1st response byte -> m_axis_tvalid=0 immediately. Next packet AD 00 08 00 07 00 00 00 -> 07 00 00 00.

Source files
------------

// File: rtl/uart_alu_engine.sv
// uart_alu_engine: framed echo/add/mul command engine between UART rx and tx byte streams.
// Define ALU_MUL_EN to decode OP_MUL; otherwise it is treated as an unknown opcode.
module uart_alu_engine #(
    parameter logic [7:0] OP_ECHO  = 8'hEC,
    parameter logic [7:0] OP_ADD   = 8'hAD,
    parameter logic [7:0] OP_MUL   = 8'h88,
    parameter logic [7:0] ERR_BYTE = 8'hEE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       busy,
    output logic       err
);
    typedef enum logic [2:0] {HDR, ECHO, ACC, RESP, DRAIN, ERR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  hcnt_q, hcnt_d;
    logic [7:0]  op_q, op_d, dat_q, dat_d;
    logic [15:0] len_q, len_d, cnt_q, cnt_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic        first_q, first_d, vld_q, vld_d, err_q, err_d, rdy_q;
    logic [23:0] opnd_q, opnd_d;
    logic [31:0] acc_q, acc_d, word, alu;
    logic        s_fire, m_fire, alu_op, mul_en;

    assign word = {s_axis_tdata, opnd_q};
`ifdef ALU_MUL_EN
    assign mul_en = 1'b1;
    assign alu    = (op_q == OP_MUL) ? acc_q * word : acc_q + word;
`else
    assign mul_en = 1'b0;
    assign alu    = acc_q + word;
`endif
    assign alu_op = (op_q == OP_ADD) || (mul_en && op_q == OP_MUL);

    // Header capture stalls for one cycle (hcnt == 4) while the packet is classified
    assign s_axis_tready = (state_q == HDR)   ? rdy_q && hcnt_q != 3'd4 :
                           (state_q == ECHO)  ? cnt_q != 16'd0 && (!vld_q || m_axis_tready) :
                           (state_q == ACC)   ? 1'b1 :
                           (state_q == DRAIN) ? cnt_q != 16'd0 : 1'b0;
    assign m_axis_tvalid = vld_q;
    assign m_axis_tdata  = (state_q == RESP) ? acc_q[{bcnt_q, 3'b000} +: 8] : dat_q;
    assign busy          = !(state_q == HDR && hcnt_q == 3'd0);
    assign err           = err_q;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign m_fire        = m_axis_tvalid && m_axis_tready;

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        op_d    = op_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        first_d = first_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        dat_d   = dat_q;
        vld_d   = vld_q;
        err_d   = 1'b0;
        case (state_q)
            HDR: begin
                if (hcnt_q == 3'd4) begin
                    hcnt_d  = 3'd0;
                    cnt_d   = len_q - 16'd4;
                    bcnt_d  = 2'd0;
                    first_d = 1'b1;
                    if (len_q < 16'd4) begin
                        state_d = ERR;
                        vld_d   = 1'b1;
                        dat_d   = ERR_BYTE;
                        err_d   = 1'b1;
                    end else if (op_q == OP_ECHO) begin
                        state_d = (len_q == 16'd4) ? HDR : ECHO;
                    end else if (alu_op && len_q != 16'd4 && len_q[1:0] == 2'b00) begin
                        state_d = ACC;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (s_fire) begin
                    hcnt_d = hcnt_q + 3'd1;
                    if (hcnt_q == 3'd0) op_d = s_axis_tdata;
                    if (hcnt_q == 3'd2) len_d[7:0] = s_axis_tdata;
                    if (hcnt_q == 3'd3) len_d[15:8] = s_axis_tdata;
                end
            end
            ECHO: begin
                if (s_fire) begin
                    dat_d = s_axis_tdata;
                    vld_d = 1'b1;
                    cnt_d = cnt_q - 16'd1;
                end else if (m_fire) begin
                    vld_d = 1'b0;
                    if (cnt_q == 16'd0) state_d = HDR;
                end
            end
            ACC: begin
                if (s_fire) begin
                    cnt_d  = cnt_q - 16'd1;
                    bcnt_d = bcnt_q + 2'd1;
                    opnd_d = {s_axis_tdata, opnd_q[23:8]};
                    if (bcnt_q == 2'd3) begin
                        acc_d   = first_q ? word : alu;
                        first_d = 1'b0;
                    end
                    if (cnt_q == 16'd1) begin
                        state_d = RESP;
                        vld_d   = 1'b1;
                    end
                end
            end
            RESP: begin
                if (m_fire) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        vld_d   = 1'b0;
                        state_d = HDR;
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == 16'd0) begin
                    state_d = ERR;
                    vld_d   = 1'b1;
                    dat_d   = ERR_BYTE;
                    err_d   = 1'b1;
                end else if (s_fire) begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ERR: begin
                if (m_fire) begin
                    vld_d   = 1'b0;
                    state_d = HDR;
                end
            end
            default: state_d = HDR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HDR;
            hcnt_q  <= 3'd0;
            op_q    <= 8'h00;
            len_q   <= 16'd0;
            cnt_q   <= 16'd0;
            bcnt_q  <= 2'd0;
            first_q <= 1'b0;
            opnd_q  <= 24'd0;
            acc_q   <= 32'd0;
            dat_q   <= 8'h00;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            op_q    <= op_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            first_q <= first_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end
endmodule
